axis_aes256_host_driver: RTL and testbench

//   PL-side initiator for the AES-256 AXIS accelerator wrapper. Takes one job per handshake
//   (128-bit plaintext, 256-bit key, round-constant vector) and serialises it as byte beats on

---
 rtl/axis_aes256_host_driver_if.sv | 12 +
 rtl/axis_aes256_host_driver.sv | 192 +++++++++++++++++++
 tb/tb_axis_aes256_host_driver.sv | 398 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_aes256_host_driver_if.sv
// Single AXI4-Stream channel: byte payload in tdata[7:0] with tvalid/tready/tlast handshake.
interface axis_aes256_host_driver_if #(
  parameter int TDATA_W = 32
);
  logic [TDATA_W-1:0] tdata;
  logic               tvalid;
  logic               tready;
  logic               tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_aes256_host_driver.sv
// Host-side driver for the AES-256 AXIS wrapper: serialises one job onto text/key/rc byte
// streams and reassembles the returned 16-byte ciphertext with tlast framing checks.
module axis_aes256_host_driver #(
  parameter int C_AXIS_TDATA_WIDTH = 32,
  parameter int TEXT_BYTES         = 16,
  parameter int KEY_BYTES          = 32,
  parameter int RC_BYTES           = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           job_valid,
  output logic                           job_ready,
  input  logic [8*TEXT_BYTES-1:0]        job_text,
  input  logic [8*KEY_BYTES-1:0]         job_key,
  input  logic [8*RC_BYTES-1:0]          job_rc,
  axis_aes256_host_driver_if.master      m00_axis,
  axis_aes256_host_driver_if.master      m01_axis,
  axis_aes256_host_driver_if.master      m02_axis,
  axis_aes256_host_driver_if.slave       s00_axis,
  output logic [8*TEXT_BYTES-1:0]        res_data,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic                           err_frame,
  output logic [15:0]                    jobs_sent,
  output logic [15:0]                    blocks_recv
);
  localparam int TW   = $clog2(TEXT_BYTES);
  localparam int KW   = $clog2(KEY_BYTES);
  localparam int RW   = $clog2(RC_BYTES);
  localparam int PADW = C_AXIS_TDATA_WIDTH - 8;
  localparam logic [TW-1:0] T_LAST = TW'(TEXT_BYTES - 1);
  localparam logic [KW-1:0] K_LAST = KW'(KEY_BYTES - 1);
  localparam logic [RW-1:0] R_LAST = RW'(RC_BYTES - 1);

  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
  typedef enum logic {RX_COLLECT, RX_HOLD} rx_state_t;

  tx_state_t r_tx_state, w_tx_next;
  rx_state_t r_rx_state, w_rx_next;

  logic [8*TEXT_BYTES-1:0]     r_text;
  logic [8*KEY_BYTES-1:0]      r_key;
  logic [8*RC_BYTES-1:0]       r_rc;
  logic [TW-1:0]               r_idx0;
  logic [KW-1:0]               r_idx1;
  logic [RW-1:0]               r_idx2;
  logic                        r_done0, r_done1, r_done2;
  logic                        w_tv0, w_tv1, w_tv2;
  logic                        w_accept, w_beat0, w_beat1, w_beat2;
  logic                        w_fin0, w_fin1, w_fin2, w_all_done;

  logic [TW-1:0]               r_rx_idx;
  logic [8*(TEXT_BYTES-1)-1:0] r_rx_buf;
  logic [7:0]                  w_rx_byte;
  logic                        w_rx_beat, w_rx_last;
  logic                        w_unused_tdata;

  assign w_accept   = job_valid & job_ready;
  assign w_beat0    = w_tv0 & m00_axis.tready;
  assign w_beat1    = w_tv1 & m01_axis.tready;
  assign w_beat2    = w_tv2 & m02_axis.tready;
  assign w_fin0     = w_beat0 & (r_idx0 == T_LAST);
  assign w_fin1     = w_beat1 & (r_idx1 == K_LAST);
  assign w_fin2     = w_beat2 & (r_idx2 == R_LAST);
  // A stream counts as drained once its final beat has gone, including this cycle's beat.
  assign w_all_done = (r_done0 | w_fin0) & (r_done1 | w_fin1) & (r_done2 | w_fin2);

  always_ff @(posedge clock) begin
    if (reset) r_tx_state <= TX_IDLE;
    else       r_tx_state <= w_tx_next;
  end

  always_comb begin
    w_tx_next = r_tx_state;
    case (r_tx_state)
      TX_IDLE: if (w_accept)   w_tx_next = TX_SEND;
      TX_SEND: if (w_all_done) w_tx_next = TX_IDLE;
      default: w_tx_next = TX_IDLE;
    endcase
  end

  always_comb begin
    job_ready        = (r_tx_state == TX_IDLE);
    w_tv0            = (r_tx_state == TX_SEND) & ~r_done0;
    w_tv1            = (r_tx_state == TX_SEND) & ~r_done1;
    w_tv2            = (r_tx_state == TX_SEND) & ~r_done2;
    m00_axis.tvalid  = w_tv0;
    m01_axis.tvalid  = w_tv1;
    m02_axis.tvalid  = w_tv2;
    m00_axis.tlast   = w_tv0 & (r_idx0 == T_LAST);
    m01_axis.tlast   = w_tv1 & (r_idx1 == K_LAST);
    m02_axis.tlast   = w_tv2 & (r_idx2 == R_LAST);
    m00_axis.tdata   = w_tv0 ? {{PADW{1'b0}}, r_text[8*r_idx0 +: 8]} : '0;
    m01_axis.tdata   = w_tv1 ? {{PADW{1'b0}}, r_key[8*r_idx1 +: 8]}  : '0;
    m02_axis.tdata   = w_tv2 ? {{PADW{1'b0}}, r_rc[8*r_idx2 +: 8]}   : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_idx0    <= '0;
      r_idx1    <= '0;
      r_idx2    <= '0;
      r_done0   <= 1'b0;
      r_done1   <= 1'b0;
      r_done2   <= 1'b0;
      jobs_sent <= '0;
    end else begin
      if (w_accept) begin
        r_idx0  <= '0;
        r_idx1  <= '0;
        r_idx2  <= '0;
        r_done0 <= 1'b0;
        r_done1 <= 1'b0;
        r_done2 <= 1'b0;
      end else begin
        if (w_beat0) begin
          if (w_fin0) r_done0 <= 1'b1;
          else        r_idx0  <= r_idx0 + TW'(1);
        end
        if (w_beat1) begin
          if (w_fin1) r_done1 <= 1'b1;
          else        r_idx1  <= r_idx1 + KW'(1);
        end
        if (w_beat2) begin
          if (w_fin2) r_done2 <= 1'b1;
          else        r_idx2  <= r_idx2 + RW'(1);
        end
      end
      if ((r_tx_state == TX_SEND) && w_all_done) jobs_sent <= jobs_sent + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_text <= job_text;
      r_key  <= job_key;
      r_rc   <= job_rc;
    end
  end

  assign w_rx_byte      = s00_axis.tdata[7:0];
  assign w_rx_beat      = s00_axis.tvalid & (r_rx_state == RX_COLLECT);
  assign w_rx_last      = w_rx_beat & (r_rx_idx == T_LAST);
  assign w_unused_tdata = ^s00_axis.tdata[C_AXIS_TDATA_WIDTH-1:8];

  always_ff @(posedge clock) begin
    if (reset) r_rx_state <= RX_COLLECT;
    else       r_rx_state <= w_rx_next;
  end

  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      RX_COLLECT: if (w_rx_last) w_rx_next = RX_HOLD;
      RX_HOLD:    if (res_ready) w_rx_next = RX_COLLECT;
      default:    w_rx_next = RX_COLLECT;
    endcase
  end

  always_comb begin
    s00_axis.tready = (r_rx_state == RX_COLLECT);
    res_valid       = (r_rx_state == RX_HOLD);
  end

  // Early tlast drops the partial block; a missing tlast on the final byte is flagged but delivered.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rx_idx    <= '0;
      res_data    <= '0;
      err_frame   <= 1'b0;
      blocks_recv <= '0;
    end else begin
      if (w_rx_beat) begin
        if (w_rx_last) begin
          res_data <= {w_rx_byte, r_rx_buf};
          r_rx_idx <= '0;
          if (!s00_axis.tlast) err_frame <= 1'b1;
        end else if (s00_axis.tlast) begin
          err_frame <= 1'b1;
          r_rx_idx  <= '0;
        end else begin
          r_rx_idx  <= r_rx_idx + TW'(1);
        end
      end
      if ((r_rx_state == RX_HOLD) && res_ready) blocks_recv <= blocks_recv + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_rx_beat && !w_rx_last) r_rx_buf[8*r_rx_idx +: 8] <= w_rx_byte;
  end
endmodule

// File: tb/tb_axis_aes256_host_driver.sv
// Randomised self-checking bench for axis_aes256_host_driver with a byte-level reference model.
module tb_axis_aes256_host_driver;
  logic         clock = 1'b0;
  logic         reset;
  logic         job_valid, job_ready;
  logic [127:0] job_text;
  logic [255:0] job_key;
  logic [127:0] job_rc;
  logic [127:0] res_data;
  logic         res_valid, res_ready, err_frame;
  logic [15:0]  jobs_sent, blocks_recv;

  always #5 clock = ~clock;

  axis_aes256_host_driver_if #(.TDATA_W(32)) m00 ();
  axis_aes256_host_driver_if #(.TDATA_W(32)) m01 ();
  axis_aes256_host_driver_if #(.TDATA_W(32)) m02 ();
  axis_aes256_host_driver_if #(.TDATA_W(32)) s00 ();

  axis_aes256_host_driver #(
    .C_AXIS_TDATA_WIDTH(32), .TEXT_BYTES(16), .KEY_BYTES(32), .RC_BYTES(16)
  ) dut (
    .clock(clock), .reset(reset),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_text(job_text), .job_key(job_key), .job_rc(job_rc),
    .m00_axis(m00), .m01_axis(m01), .m02_axis(m02), .s00_axis(s00),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .err_frame(err_frame), .jobs_sent(jobs_sent), .blocks_recv(blocks_recv)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // captured TX beats {tlast, tdata}
  logic [32:0]  cap [3][64];
  int           ncap [3];
  logic [127:0] resq [$];

  // reference model state
  int           exp_jobs, exp_blocks, acc;
  bit           exp_err;
  logic [127:0] accv;
  logic [127:0] exp_res [$];

  function automatic logic [32:0] exp_beat(input int s, input int i, input logic [127:0] t,
                                           input logic [255:0] k, input logic [127:0] r);
    int         n;
    logic [7:0] b;
    n = (s == 1) ? 32 : 16;
    b = (s == 0) ? t[8*i +: 8] : (s == 1) ? k[8*i +: 8] : r[8*i +: 8];
    return {(i == n - 1), 24'h0, b};
  endfunction

  // monitor: capture beats, check AXIS hold rule and result hold rule
  initial begin
    logic        tv [3];
    logic        tr [3];
    logic [32:0] td [3];
    logic [32:0] prev [3];
    bit          stall [3];
    bit          hold_prev;
    logic [127:0] prev_res;
    for (int s = 0; s < 3; s++) begin stall[s] = 0; ncap[s] = 0; end
    hold_prev = 0;
    forever begin
      @(negedge clock);
      tv[0] = m00.tvalid; tr[0] = m00.tready; td[0] = {m00.tlast, m00.tdata};
      tv[1] = m01.tvalid; tr[1] = m01.tready; td[1] = {m01.tlast, m01.tdata};
      tv[2] = m02.tvalid; tr[2] = m02.tready; td[2] = {m02.tlast, m02.tdata};
      if (reset) begin
        for (int s = 0; s < 3; s++) stall[s] = 0;
        hold_prev = 0;
      end else begin
        for (int s = 0; s < 3; s++) begin
          if (stall[s]) begin
            n_checks++;
            if (tv[s] !== 1'b1 || td[s] !== prev[s])
              $display("FAIL stall_hold_s%0d: got v=%b beat=%h, need v=1 beat=%h", s, tv[s], td[s], prev[s]);
            else n_pass++;
          end
          if (tv[s] && tr[s] && ncap[s] < 64) begin cap[s][ncap[s]] = td[s]; ncap[s]++; end
          stall[s] = tv[s] && !tr[s];
          prev[s]  = td[s];
        end
        if (hold_prev) begin
          n_checks++;
          if (res_valid !== 1'b1 || res_data !== prev_res)
            $display("FAIL res_hold: got v=%b d=%h, need v=1 d=%h", res_valid, res_data, prev_res);
          else n_pass++;
        end
        if (res_valid && res_ready) resq.push_back(res_data);
        hold_prev = res_valid && !res_ready;
        prev_res  = res_data;
      end
    end
  end

  task automatic run_job(input logic [127:0] t, input logic [255:0] k, input logic [127:0] r, input bit bp);
    bit ok;
    bit bad;
    int n;
    for (int s = 0; s < 3; s++) ncap[s] = 0;
    @(posedge clock); #1;
    job_text = t; job_key = k; job_rc = r; job_valid = 1'b1;
    if (bp) begin m00.tready = 1'($urandom); m01.tready = 1'b0; m02.tready = 1'($urandom); end
    @(posedge clock); #1;
    job_valid = 1'b0;
    @(negedge clock);
    n_checks++;
    if ({m00.tvalid, m01.tvalid, m02.tvalid, job_ready} !== 4'b1110)
      $display("FAIL accept_latency: got tvalid=%b%b%b job_ready=%b, need 111 0", m00.tvalid, m01.tvalid, m02.tvalid, job_ready);
    else n_pass++;
    ok = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (job_ready) begin ok = 1; break; end
      @(posedge clock); #1;
      if (bp) begin
        m00.tready = 1'($urandom);
        m01.tready = (cyc < 50) ? 1'b0 : 1'($urandom);
        m02.tready = 1'($urandom);
      end
      @(negedge clock);
    end
    n_checks++;
    if (!ok) $display("FAIL job_drain_timeout: got job_ready=%b, need 1", job_ready);
    else n_pass++;
    exp_jobs++;
    n_checks++;
    if (jobs_sent !== 16'(exp_jobs)) $display("FAIL jobs_sent: got %0d, need %0d", jobs_sent, exp_jobs);
    else n_pass++;
    n_checks++;
    if ({m00.tvalid, m01.tvalid, m02.tvalid} !== 3'b000)
      $display("FAIL tvalid_after_drain: got %b%b%b, need 000", m00.tvalid, m01.tvalid, m02.tvalid);
    else n_pass++;
    for (int s = 0; s < 3; s++) begin
      n = (s == 1) ? 32 : 16;
      n_checks++;
      if (ncap[s] != n) $display("FAIL beat_count_s%0d: got %0d, need %0d", s, ncap[s], n);
      else n_pass++;
      bad = 0;
      for (int i = 0; i < n && i < ncap[s]; i++) begin
        if (!bad && cap[s][i] !== exp_beat(s, i, t, k, r)) begin
          bad = 1;
          $display("FAIL beat_data_s%0d[%0d]: got %h, need %h", s, i, cap[s][i], exp_beat(s, i, t, k, r));
        end
      end
      n_checks++;
      if (!bad) n_pass++;
    end
    @(posedge clock); #1;
    m00.tready = 1'b1; m01.tready = 1'b1; m02.tready = 1'b1;
  endtask

  task automatic rx_beat(input logic [7:0] b, input bit last);
    bit ok;
    ok = 0;
    s00.tvalid = 1'b1;
    s00.tdata  = {24'($urandom), b};
    s00.tlast  = last;
    for (int w = 0; w < 300; w++) begin
      @(negedge clock);
      ok = s00.tready;
      @(posedge clock); #1;
      if (ok) break;
    end
    s00.tvalid = 1'b0;
    s00.tlast  = 1'b0;
    n_checks++;
    if (!ok) $display("FAIL rx_beat_timeout: got tready=0, need 1");
    else begin
      n_pass++;
      if (acc == 15) begin
        accv[127:120] = b;
        exp_res.push_back(accv);
        exp_blocks++;
        if (!last) exp_err = 1;
        acc = 0;
      end else if (last) begin
        exp_err = 1;
        acc = 0;
      end else begin
        accv[8*acc +: 8] = b;
        acc++;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    n_checks++;
    if (job_ready !== 1'b1 || s00.tready !== 1'b1)
      $display("FAIL reset_ready: got job_ready=%b s00_tready=%b, need 1 1", job_ready, s00.tready);
    else n_pass++;
    n_checks++;
    if ({m00.tvalid, m01.tvalid, m02.tvalid, m00.tlast, m01.tlast, m02.tlast} !== 6'b0)
      $display("FAIL reset_tvalid_tlast: got %b%b%b %b%b%b, need 000 000",
               m00.tvalid, m01.tvalid, m02.tvalid, m00.tlast, m01.tlast, m02.tlast);
    else n_pass++;
    n_checks++;
    if ({m00.tdata, m01.tdata, m02.tdata} !== 96'b0)
      $display("FAIL reset_tdata: got %h %h %h, need 0", m00.tdata, m01.tdata, m02.tdata);
    else n_pass++;
    n_checks++;
    if (res_valid !== 1'b0 || res_data !== 128'b0 || err_frame !== 1'b0)
      $display("FAIL reset_result: got v=%b d=%h err=%b, need 0 0 0", res_valid, res_data, err_frame);
    else n_pass++;
    n_checks++;
    if (jobs_sent !== 16'd0 || blocks_recv !== 16'd0)
      $display("FAIL reset_counters: got %0d %0d, need 0 0", jobs_sent, blocks_recv);
    else n_pass++;
  endtask

  task automatic test_fips_job();
    logic [255:0] k;
    logic [127:0] r;
    logic [7:0]   rc;
    rc = 8'h01;
    for (int i = 0; i < 32; i++) k[8*i +: 8] = 8'(i);
    for (int i = 0; i < 16; i++) begin
      r[8*i +: 8] = rc;
      rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
    end
    run_job(128'hffeeddccbbaa99887766554433221100, k, r, 1'b0);
    n_checks++;
    if (cap[0][15] !== {1'b1, 24'h0, 8'hff} || cap[1][31] !== {1'b1, 24'h0, 8'h1f})
      $display("FAIL fips_last_beats: got %h %h, need 1000000ff 10000001f", cap[0][15], cap[1][31]);
    else n_pass++;
    n_checks++;
    if (jobs_sent !== 16'd1) $display("FAIL fips_jobs_sent: got %0d, need 1", jobs_sent);
    else n_pass++;
  endtask

  task automatic test_fips_rx();
    logic [7:0] ct [16] = '{8'h8e, 8'ha2, 8'hb7, 8'hca, 8'h51, 8'h67, 8'h45, 8'hbf,
                           8'hea, 8'hfc, 8'h49, 8'h90, 8'h4b, 8'h49, 8'h60, 8'h89};
    @(posedge clock); #1;
    for (int i = 0; i < 16; i++) rx_beat(ct[i], i == 15);
    repeat (4) @(negedge clock);
    n_checks++;
    if (resq.size() != 1 || resq[0] !== 128'h8960494b9049fceabf456751cab7a28e)
      $display("FAIL fips_result: got n=%0d d=%h, need n=1 d=8960494b9049fceabf456751cab7a28e",
               resq.size(), (resq.size() > 0) ? resq[0] : 128'h0);
    else n_pass++;
    n_checks++;
    if (blocks_recv !== 16'd1 || err_frame !== 1'b0)
      $display("FAIL fips_rx_status: got blocks=%0d err=%b, need 1 0", blocks_recv, err_frame);
    else n_pass++;
    resq.delete();
    exp_res.delete();
  endtask

  task automatic test_backpressure();
    for (int j = 0; j < 2; j++)
      run_job({$urandom, $urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom, $urandom}, 1'b1);
  endtask

  task automatic test_rx_framing();
    bit bad;
    @(posedge clock); #1;
    for (int i = 0; i < 5; i++)  rx_beat(8'($urandom), i == 4);
    for (int i = 0; i < 16; i++) rx_beat(8'($urandom), i == 15);
    for (int i = 0; i < 16; i++) rx_beat(8'($urandom), 1'b0);
    repeat (4) @(negedge clock);
    n_checks++;
    if (resq.size() != exp_res.size()) $display("FAIL framing_count: got %0d, need %0d", resq.size(), exp_res.size());
    else n_pass++;
    bad = 0;
    for (int i = 0; i < resq.size() && i < exp_res.size(); i++)
      if (!bad && resq[i] !== exp_res[i]) begin
        bad = 1;
        $display("FAIL framing_data[%0d]: got %h, need %h", i, resq[i], exp_res[i]);
      end
    n_checks++;
    if (!bad) n_pass++;
    n_checks++;
    if (err_frame !== exp_err || blocks_recv !== 16'(exp_blocks))
      $display("FAIL framing_status: got err=%b blocks=%0d, need %b %0d", err_frame, blocks_recv, exp_err, exp_blocks);
    else n_pass++;
    resq.delete();
    exp_res.delete();
  endtask

  task automatic test_hold();
    logic [127:0] held;
    bit bad_rdy, bad_vld, bad_dat;
    bit bad;
    bad_rdy = 0; bad_vld = 0; bad_dat = 0;
    @(posedge clock); #1;
    res_ready = 1'b0;
    for (int i = 0; i < 16; i++) rx_beat(8'($urandom), i == 15);
    held = exp_res[exp_res.size() - 1];
    fork
      begin
        for (int i = 0; i < 16; i++) rx_beat(8'($urandom), i == 15);
      end
      begin
        repeat (20) begin
          @(negedge clock);
          if (s00.tready !== 1'b0) bad_rdy = 1;
          if (res_valid !== 1'b1)  bad_vld = 1;
          if (res_data !== held)   bad_dat = 1;
        end
        @(posedge clock); #1;
        res_ready = 1'b1;
      end
    join
    n_checks++;
    if (bad_rdy) $display("FAIL hold_tready: got 1 during hold, need 0"); else n_pass++;
    n_checks++;
    if (bad_vld) $display("FAIL hold_res_valid: got 0 during hold, need 1"); else n_pass++;
    n_checks++;
    if (bad_dat) $display("FAIL hold_res_data: got %h, need %h", res_data, held); else n_pass++;
    repeat (4) @(negedge clock);
    bad = (resq.size() != exp_res.size());
    for (int i = 0; i < resq.size() && i < exp_res.size(); i++) if (resq[i] !== exp_res[i]) bad = 1;
    n_checks++;
    if (bad) $display("FAIL hold_results: got %0d blocks, need %0d matching", resq.size(), exp_res.size());
    else n_pass++;
    n_checks++;
    if (blocks_recv !== 16'(exp_blocks)) $display("FAIL hold_blocks: got %0d, need %0d", blocks_recv, exp_blocks);
    else n_pass++;
    resq.delete();
    exp_res.delete();
  endtask

  task automatic test_reset_mid();
    bit reached;
    @(posedge clock); #1;
    for (int i = 0; i < 3; i++) rx_beat(8'($urandom), 1'b0);
    for (int s = 0; s < 3; s++) ncap[s] = 0;
    job_text = {$urandom, $urandom, $urandom, $urandom};
    job_key  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    job_rc   = {$urandom, $urandom, $urandom, $urandom};
    job_valid = 1'b1;
    @(posedge clock); #1;
    job_valid = 1'b0;
    reached = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clock);
      if (ncap[1] >= 10) begin reached = 1; break; end
    end
    n_checks++;
    if (!reached) $display("FAIL midreset_reach_key10: got %0d key beats, need 10", ncap[1]);
    else n_pass++;
    #1 reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    exp_jobs = 0; exp_blocks = 0; exp_err = 0; acc = 0;
    exp_res.delete();
    @(negedge clock);
    n_checks++;
    if ({m00.tvalid, m01.tvalid, m02.tvalid, m01.tlast} !== 4'b0000 || job_ready !== 1'b1)
      $display("FAIL midreset_tx: got tvalid=%b%b%b tlast=%b job_ready=%b, need 000 0 1",
               m00.tvalid, m01.tvalid, m02.tvalid, m01.tlast, job_ready);
    else n_pass++;
    n_checks++;
    if (jobs_sent !== 16'd0 || blocks_recv !== 16'd0 || err_frame !== 1'b0)
      $display("FAIL midreset_status: got jobs=%0d blocks=%0d err=%b, need 0 0 0", jobs_sent, blocks_recv, err_frame);
    else n_pass++;
    resq.delete();
    run_job({$urandom, $urandom, $urandom, $urandom},
            {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
            {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    for (int i = 0; i < 16; i++) rx_beat(8'($urandom), i == 15);
    repeat (4) @(negedge clock);
    n_checks++;
    if (resq.size() != 1 || exp_res.size() != 1 || resq[0] !== exp_res[0])
      $display("FAIL midreset_rx_block: got n=%0d d=%h, need n=1 d=%h", resq.size(),
               (resq.size() > 0) ? resq[0] : 128'h0, (exp_res.size() > 0) ? exp_res[0] : 128'h0);
    else n_pass++;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish, need finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; job_valid = 1'b0; job_text = '0; job_key = '0; job_rc = '0; res_ready = 1'b1;
    m00.tready = 1'b1; m01.tready = 1'b1; m02.tready = 1'b1;
    s00.tvalid = 1'b0; s00.tdata = '0; s00.tlast = 1'b0;
    exp_jobs = 0; exp_blocks = 0; exp_err = 0; acc = 0; accv = '0;
    test_reset();
    test_fips_job();
    test_fips_rx();
    test_backpressure();
    test_rx_framing();
    test_hold();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
